apb_master_bridge: RTL and testbench

- APB requester (master) that turns a simple valid/ready command interface into single APB3 transfers to one slave.
- Returns the read data and error status through a one-entry, backpressured response interface.
- Sits between on-chip control logic (or a testbench driver) and the APB slave under test.
- Enforces the SETUP/ACCESS protocol and adds a programmable wait-state timeout so a hung slave cannot stall the system.

---
 rtl/apb_master_bridge_if.sv | 41 ++++
 rtl/apb_master_bridge.sv | 145 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command, response and APB signal bundle for apb_master_bridge
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    // master: the bridge itself; slave: whatever drives commands and models the APB target
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PWRITE, PWDATA, PSELx, PENABLE
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PWRITE, PWDATA, PSELx, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to single APB3 transfer bridge with wait-state timeout
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic cmd_ready_int;
    logic psel;
    logic penable;
    logic accept;
    logic done_ok;
    logic done_to;

    // A response slot that is being drained this cycle counts as free.
    assign cmd_ready_int = (state == ST_IDLE) && (!rsp_valid_q || bus.rsp_ready);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_int) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (bus.PREADY) begin
                    done_ok    = 1'b1;
                    state_next = ST_IDLE;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                    done_to    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address/direction/data are captured once at accept and held until the next accept.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (accept) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !bus.PREADY && !done_to && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Completion can only happen when the slot is empty, so nothing is ever overwritten.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (done_ok) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
        end else if (done_to) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
        end else if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign bus.cmd_ready   = cmd_ready_int;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSELx   = psel;
    assign bus.PENABLE = penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a behavioural APB slave
module tb_apb_master_bridge;

    logic pclk;
    logic presetn;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb_q[$];

    int          sl_wait;
    logic        sl_err;
    logic        sl_hang;
    logic [31:0] sl_rdata;
    int          acc_n;
    int          last_acc;

    apb_master_bridge_if bus ();

    apb_master_bridge #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK   (pclk),
        .PRESETn(presetn),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    // Slave answers after sl_wait ACCESS cycles; PRDATA/PSLVERR carry junk otherwise.
    always @(negedge pclk) begin
        if (bus.PSELx && bus.PENABLE) begin
            if (!sl_hang && acc_n == sl_wait) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = sl_rdata;
                bus.PSLVERR = sl_err;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end
            acc_n++;
        end else begin
            bus.PREADY  = 1'b0;
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom_range(0, 1));
            acc_n       = 0;
        end
    end

    logic [31:0] snap_addr;
    logic [32:0] snap_wd;
    logic        hold_q;
    logic [33:0] held;

    always begin
        @(negedge pclk);
        #2;
        if (!presetn) begin
            hold_q = 1'b0;
        end else begin
            chk("penable_needs_psel", 64'(bus.PENABLE && !bus.PSELx), 0);
            if (bus.PSELx && !bus.PENABLE) begin
                snap_addr = bus.PADDR;
                snap_wd   = {bus.PWRITE, bus.PWDATA};
            end else if (bus.PSELx) begin
                chk("paddr_stable", 64'(bus.PADDR), 64'(snap_addr));
                chk("pwrite_pwdata_stable", 64'({bus.PWRITE, bus.PWDATA}), 64'(snap_wd));
            end
            if (hold_q) begin
                chk("rsp_hold_valid", 64'(bus.rsp_valid), 1);
                chk("rsp_hold_fields", 64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 64'(held));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'(sb_q.size()), 1);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
                end
            end
            hold_q = bus.rsp_valid && !bus.rsp_ready;
            held   = {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input logic et);
        rsp_t e;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
        chk("cmd_accept", 64'(bus.cmd_ready), 1);
        last_acc = cyc;
        e.rdata  = er;
        e.err    = ee;
        e.to     = et;
        sb_q.push_back(e);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
        chk("drain", 64'(sb_q.size()), 0);
        tick();
    endtask

    task automatic count_sel(output int n);
        n = 0;
        for (int i = 0; i < 40 && bus.PSELx; i++) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n_sel;
        int first_acc;
        cyc           = 0;
        n_checks      = 0;
        n_errors      = 0;
        acc_n         = 0;
        sl_wait       = 0;
        sl_err        = 1'b0;
        sl_hang       = 1'b0;
        sl_rdata      = 32'h0;
        hold_q        = 1'b0;
        presetn       = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h55;
        bus.cmd_wdata = 32'h66;

        // Reset with a command pending: nothing may start.
        repeat (3) tick();
        chk("rst_psel", 64'(bus.PSELx), 0);
        chk("rst_penable", 64'(bus.PENABLE), 0);
        chk("rst_pwrite", 64'(bus.PWRITE), 0);
        chk("rst_paddr", 64'(bus.PADDR), 0);
        chk("rst_pwdata", 64'(bus.PWDATA), 0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 0);
        chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 0);
        bus.cmd_valid = 1'b0;
        presetn = 1'b1;
        tick();

        // Zero-wait write with latency checks.
        sl_wait  = 0;
        sl_rdata = 32'hFFFF0000;
        send(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        chk("wr_setup_psel", 64'(bus.PSELx), 1);
        chk("wr_setup_penable", 64'(bus.PENABLE), 0);
        chk("wr_paddr", 64'(bus.PADDR), 64'h10);
        chk("wr_pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
        chk("wr_pwrite", 64'(bus.PWRITE), 1);
        tick();
        chk("wr_access_penable", 64'(bus.PENABLE), 1);
        chk("wr_access_rsp_valid", 64'(bus.rsp_valid), 0);
        tick();
        chk("wr_rsp_valid_lat3", 64'(bus.rsp_valid), 1);
        chk("wr_psel_drop", 64'(bus.PSELx), 0);
        drain();

        // Read with 3 wait states.
        sl_wait  = 3;
        sl_err   = 1'b0;
        sl_rdata = 32'h12345678;
        send(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b0);
        chk("rd_paddr", 64'(bus.PADDR), 64'h20);
        count_sel(n_sel);
        chk("rd_wait_psel_cycles", 64'(n_sel), 5);
        drain();

        // PSLVERR on the ready cycle, then a normal follow-up.
        sl_wait  = 1;
        sl_err   = 1'b1;
        sl_rdata = 32'hCAFEF00D;
        send(1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        drain();
        sl_wait = 0;
        sl_err  = 1'b0;
        send(1'b1, 32'h28, 32'h00C0FFEE, 32'h0, 1'b0, 1'b0);
        drain();

        // Hung slave: timeout after 4 ACCESS cycles.
        sl_hang = 1'b1;
        send(1'b0, 32'h2C, 32'h0, 32'h0, 1'b1, 1'b1);
        count_sel(n_sel);
        chk("to_psel_cycles", 64'(n_sel), 5);
        sl_hang = 1'b0;
        drain();

        // Response backpressure with a second command queued.
        bus.rsp_ready = 1'b0;
        sl_rdata      = 32'hA5A55A5A;
        send(1'b0, 32'h30, 32'h0, 32'hA5A55A5A, 1'b0, 1'b0);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h34;
        bus.cmd_wdata = 32'h0BADC0DE;
        bus.cmd_valid = 1'b1;
        tick();
        tick();
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready_low", 64'(bus.cmd_ready), 0);
            chk("bp_no_setup", 64'(bus.PSELx), 0);
            chk("bp_rdata_held", 64'(bus.rsp_rdata), 64'hA5A55A5A);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_cmd_ready_on_drain", 64'(bus.cmd_ready), 1);
        begin
            rsp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            e.to    = 1'b0;
            sb_q.push_back(e);
        end
        tick();
        bus.cmd_valid = 1'b0;
        chk("bp_second_setup", 64'(bus.PSELx), 1);
        chk("bp_second_addr", 64'(bus.PADDR), 64'h34);
        drain();

        // Back-to-back zero-wait throughput.
        sl_wait = 0;
        send(1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0, 1'b0);
        first_acc = last_acc;
        send(1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0, 1'b0);
        chk("b2b_spacing", 64'(last_acc - first_acc), 3);
        drain();

        // Random single transfers.
        for (int i = 0; i < 6; i++) begin
            logic        w;
            logic        er;
            logic [31:0] rd;
            w        = 1'($urandom_range(0, 1));
            er       = 1'($urandom_range(0, 1));
            rd       = $urandom;
            sl_wait  = $urandom_range(0, 2);
            sl_err   = er;
            sl_rdata = rd;
            send(w, $urandom, $urandom, w ? 32'h0 : rd, er, 1'b0);
            drain();
        end
        sl_err = 1'b0;

        // Asynchronous reset mid-ACCESS discards the transfer.
        sl_wait = 3;
        send(1'b1, 32'h50, 32'h77777777, 32'h0, 1'b0, 1'b0);
        tick();
        chk("rst_mid_in_access", 64'(bus.PENABLE), 1);
        presetn = 1'b0;
        #1;
        chk("rst_mid_psel", 64'(bus.PSELx), 0);
        chk("rst_mid_penable", 64'(bus.PENABLE), 0);
        chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 0);
        sb_q.delete();
        tick();
        tick();
        presetn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 1);
        sl_wait = 0;
        send(1'b1, 32'h54, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0);
        chk("post_rst_paddr", 64'(bus.PADDR), 64'h54);
        drain();

        chk("sb_left", 64'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
